// File: rtl/pipe_seq_ctrl_pkg.sv
// ============================================================================
// pipe_seq_ctrl_pkg : shared types and stage indices for the pipeline sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipe_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      PS_IDLE     = 2'd0,
      PS_RUN      = 2'd1,
      PS_REDIRECT = 2'd2,
      PS_DRAIN    = 2'd3
   } pipe_state_t;

   localparam int unsigned NUM_STAGES = 4;
   localparam int unsigned ST_DEC     = 0;
   localparam int unsigned ST_REG     = 1;
   localparam int unsigned ST_ALU     = 2;
   localparam int unsigned ST_WB      = 3;

   // Advance the valid chain one stage toward wb, inserting in_bit at decode.
   function automatic logic [NUM_STAGES-1:0] shift_chain(
      input logic [NUM_STAGES-1:0] v,
      input logic                  in_bit
   );
      return {v[NUM_STAGES-2:0], in_bit};
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_perf_cnt.sv
// ============================================================================
// pipe_perf_cnt : stall / bubble event counters, wrap at 2^CNT_W
// Built only when PIPE_PERF_CNT_EN is defined.  Revision: 1.0
// ============================================================================
`default_nettype none

`ifdef PIPE_PERF_CNT_EN
module pipe_perf_cnt #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             arstn,
   input  logic             stall_inc_i,
   input  logic             bubble_inc_i,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] bubble_cnt_o
);

   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] bubble_q;

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         if (stall_inc_i)  stall_q  <= stall_q + CNT_W'(1);
         if (bubble_inc_i) bubble_q <= bubble_q + CNT_W'(1);
      end
   end

   assign stall_cnt_o  = stall_q;
   assign bubble_cnt_o = bubble_q;

endmodule
`endif

`default_nettype wire

// File: rtl/pipe_seq_ctrl.sv
// ============================================================================
// pipe_seq_ctrl : 5-stage pipeline sequencer (advance, bubbles, branch redirect)
// Perf counters built only with PIPE_PERF_CNT_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_seq_ctrl
   import pipe_seq_ctrl_pkg::*;
#(
   parameter int unsigned STALL_TIMEOUT = 15,
   parameter int unsigned CNT_W         = 32
) (
   input  logic                  clk,
   input  logic                  arstn,
   input  logic                  start_i,
   input  logic                  halt_i,
   input  logic                  reg_conflict_i,
   input  logic                  branch_conflict_i,
   input  logic                  wb_branch_done_i,
   output logic                  fetch_en_o,
   output logic                  dec_en_o,
   output logic                  reg_en_o,
   output logic                  alu_en_o,
   output logic                  wb_en_o,
   output logic                  pc_load_o,
   output logic [NUM_STAGES-1:0] vld_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  stall_err_o,
   output logic [CNT_W-1:0]      perf_stall_o,
   output logic [CNT_W-1:0]      perf_bubble_o
);

   localparam logic [1:0] S_IDLE     = PS_IDLE;
   localparam logic [1:0] S_RUN      = PS_RUN;
   localparam logic [1:0] S_REDIRECT = PS_REDIRECT;
   localparam logic [1:0] S_DRAIN    = PS_DRAIN;

   localparam int unsigned    SC_W   = $clog2(STALL_TIMEOUT + 1);
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(STALL_TIMEOUT);

   logic [1:0]            state_q,     state_d;
   logic [NUM_STAGES-1:0] vld_q,       vld_d;
   logic [SC_W-1:0]       stall_cnt_q, stall_cnt_d;
   logic                  stall_err_q, stall_err_d;

   logic run_live;
   logic stall;
   logic normal;

   // Redirect and halt outrank both conflict flags in RUN.
   assign run_live = (state_q == S_RUN) & ~wb_branch_done_i & ~halt_i;
   assign stall    = run_live & reg_conflict_i & vld_q[ST_DEC];
   assign normal   = run_live & ~stall & ~branch_conflict_i;

   always_comb begin
      state_d = state_q;
      vld_d   = vld_q;
      case (state_q)
         S_IDLE: begin
            vld_d = '0;
            if (start_i) state_d = S_RUN;
         end
         S_RUN: begin
            if (stall)
               vld_d = {vld_q[ST_ALU], vld_q[ST_REG], 1'b0, vld_q[ST_DEC]};
            else
               vld_d = shift_chain(vld_q, normal);
            if (wb_branch_done_i)  state_d = S_REDIRECT;
            else if (halt_i)       state_d = S_DRAIN;
         end
         S_REDIRECT: begin
            vld_d   = shift_chain(vld_q, 1'b0);
            state_d = S_RUN;
         end
         S_DRAIN: begin
            vld_d = shift_chain(vld_q, 1'b0);
            if (vld_q == '0) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            vld_d   = '0;
         end
      endcase
   end

   always_comb begin
      stall_cnt_d = '0;
      if (stall)
         stall_cnt_d = (stall_cnt_q == SC_MAX) ? stall_cnt_q : stall_cnt_q + SC_W'(1);
      stall_err_d = stall_err_q | (stall_cnt_d == SC_MAX);
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q     <= S_IDLE;
         vld_q       <= '0;
         stall_cnt_q <= '0;
         stall_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         vld_q       <= vld_d;
         stall_cnt_q <= stall_cnt_d;
         stall_err_q <= stall_err_d;
      end
   end

   assign fetch_en_o  = normal;
   assign dec_en_o    = vld_q[ST_DEC] & ~stall;
   assign reg_en_o    = vld_q[ST_REG];
   assign alu_en_o    = vld_q[ST_ALU];
   assign wb_en_o     = vld_q[ST_WB];
   assign pc_load_o   = (state_q == S_REDIRECT);
   assign vld_o       = vld_q;
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DRAIN) & (vld_q == '0);
   assign stall_err_o = stall_err_q;

`ifdef PIPE_PERF_CNT_EN
   logic bubble_inc;

   // A branch gate costs a bubble only if it displaced a live decode slot.
   assign bubble_inc = stall |
                       (run_live & ~stall & branch_conflict_i & vld_q[ST_DEC]);

   pipe_perf_cnt #(
      .CNT_W (CNT_W)
   ) u_perf_cnt (
      .clk          (clk),
      .arstn        (arstn),
      .stall_inc_i  (stall),
      .bubble_inc_i (bubble_inc),
      .stall_cnt_o  (perf_stall_o),
      .bubble_cnt_o (perf_bubble_o)
   );
`else
   assign perf_stall_o  = '0;
   assign perf_bubble_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_seq_ctrl.sv
// ============================================================================
// tb_pipe_seq_ctrl : vector table, directed corner sequences and random run
// against a stage-list reference model.  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pipe_seq_ctrl;

   localparam int unsigned STALL_TIMEOUT = 15;
   localparam int unsigned CNT_W         = 32;

   logic clk   = 1'b0;
   logic arstn = 1'b0;
   logic start_i = 1'b0, halt_i = 1'b0, reg_conflict_i = 1'b0;
   logic branch_conflict_i = 1'b0, wb_branch_done_i = 1'b0;
   logic fetch_en_o, dec_en_o, reg_en_o, alu_en_o, wb_en_o, pc_load_o;
   logic busy_o, done_o, stall_err_o;
   logic [3:0]       vld_o;
   logic [CNT_W-1:0] perf_stall_o, perf_bubble_o;

   int total = 0;
   int bad   = 0;
   logic done_seen;

   always #5 clk = ~clk;

   pipe_seq_ctrl #(
      .STALL_TIMEOUT (STALL_TIMEOUT),
      .CNT_W         (CNT_W)
   ) dut (
      .clk               (clk),
      .arstn             (arstn),
      .start_i           (start_i),
      .halt_i            (halt_i),
      .reg_conflict_i    (reg_conflict_i),
      .branch_conflict_i (branch_conflict_i),
      .wb_branch_done_i  (wb_branch_done_i),
      .fetch_en_o        (fetch_en_o),
      .dec_en_o          (dec_en_o),
      .reg_en_o          (reg_en_o),
      .alu_en_o          (alu_en_o),
      .wb_en_o           (wb_en_o),
      .pc_load_o         (pc_load_o),
      .vld_o             (vld_o),
      .busy_o            (busy_o),
      .done_o            (done_o),
      .stall_err_o       (stall_err_o),
      .perf_stall_o      (perf_stall_o),
      .perf_bubble_o     (perf_bubble_o)
   );

   typedef struct {
      bit         start, halt, rc, bc, wbd;
      bit         fetch, dec_en, pcl, busy, done;
      logic [3:0] vld;
   } vec_t;

   // Reference model: mode of operation plus a list of stage occupancies.
   typedef enum int {M_IDLE, M_RUN, M_REDIR, M_DRAIN} mmode_t;
   mmode_t           m_mode;
   bit               m_stg [0:3];   // 0=dec .. 3=wb
   int               m_stall_run;
   bit               m_err;
   logic [CNT_W-1:0] m_ps, m_pb;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_mode      = M_IDLE;
      foreach (m_stg[i]) m_stg[i] = 1'b0;
      m_stall_run = 0;
      m_err       = 1'b0;
      m_ps        = '0;
      m_pb        = '0;
   endfunction

   function automatic void classify(output bit st, output bit br, output bit nm);
      bit live;
      live = (m_mode == M_RUN) && !wb_branch_done_i && !halt_i;
      st   = live && reg_conflict_i && m_stg[0];
      br   = live && !st && branch_conflict_i;
      nm   = live && !st && !branch_conflict_i;
   endfunction

   task automatic model_check();
      bit st, br, nm;
      logic [3:0] ev;
      logic [CNT_W-1:0] eps, epb;
      classify(st, br, nm);
      ev = {m_stg[3], m_stg[2], m_stg[1], m_stg[0]};
      chk("m.enables", {fetch_en_o, dec_en_o, reg_en_o, alu_en_o, wb_en_o},
          {nm, m_stg[0] && !st, m_stg[1], m_stg[2], m_stg[3]});
      chk("m.vld", vld_o, ev);
      chk("m.status", {busy_o, done_o, pc_load_o, stall_err_o},
          {m_mode != M_IDLE, (m_mode == M_DRAIN) && (ev == 4'd0), m_mode == M_REDIR, m_err});
`ifdef PIPE_PERF_CNT_EN
      eps = m_ps; epb = m_pb;
`else
      eps = '0;   epb = '0;
`endif
      chk("m.perf_stall", perf_stall_o, eps);
      chk("m.perf_bubble", perf_bubble_o, epb);
   endtask

   task automatic model_step();
      bit st, br, nm, d0, was_empty;
      classify(st, br, nm);
      d0        = m_stg[0];
      was_empty = !(m_stg[0] || m_stg[1] || m_stg[2] || m_stg[3]);
      if (m_mode == M_IDLE) begin
         if (start_i) m_mode = M_RUN;
      end else begin
         m_stg[3] = m_stg[2];
         m_stg[2] = m_stg[1];
         m_stg[1] = st ? 1'b0 : d0;
         m_stg[0] = st ? d0 : nm;
         if (st) m_ps = m_ps + 1;
         if (st || (br && d0)) m_pb = m_pb + 1;
         case (m_mode)
            M_RUN:   if (wb_branch_done_i) m_mode = M_REDIR;
                     else if (halt_i)      m_mode = M_DRAIN;
            M_REDIR: m_mode = M_RUN;
            M_DRAIN: if (was_empty) m_mode = M_IDLE;
            default: ;
         endcase
      end
      if (st) m_stall_run = (m_stall_run < STALL_TIMEOUT) ? m_stall_run + 1 : m_stall_run;
      else    m_stall_run = 0;
      if (m_stall_run == STALL_TIMEOUT) m_err = 1'b1;
   endtask

   function automatic vec_t mk(bit s, bit h, bit rc, bit bc, bit wbd);
      vec_t v;
      v = '{s, h, rc, bc, wbd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
      return v;
   endfunction

   // Called just after a rising edge; returns just after the next one.
   task automatic step(input vec_t v, input bit use_tbl, input string tag);
      start_i           = v.start;
      halt_i            = v.halt;
      reg_conflict_i    = v.rc;
      branch_conflict_i = v.bc;
      wb_branch_done_i  = v.wbd;
      @(negedge clk);
      model_check();
      done_seen = done_o;
      if (use_tbl) begin
         chk({tag, ".fetch"},  fetch_en_o, v.fetch);
         chk({tag, ".dec_en"}, dec_en_o,   v.dec_en);
         chk({tag, ".pc_load"}, pc_load_o, v.pcl);
         chk({tag, ".busy"},   busy_o,     v.busy);
         chk({tag, ".done"},   done_o,     v.done);
         chk({tag, ".vld"},    vld_o,      v.vld);
      end
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic sync_reset_pulse();
      start_i = 0; halt_i = 0; reg_conflict_i = 0; branch_conflict_i = 0; wb_branch_done_i = 0;
      arstn = 1'b0;
      model_reset();
      @(posedge clk);
      #1 arstn = 1'b1;
   endtask

   vec_t tbl [0:22];
   vec_t v;
   int   k;
   int   rc_hold;
   logic [CNT_W-1:0] exp_ps, exp_pb;

   initial begin
      tbl[0]  = '{1,0,0,0,0, 0,0,0,0,0, 4'b0000};
      tbl[1]  = '{0,0,0,0,0, 1,0,0,1,0, 4'b0000};
      tbl[2]  = '{0,0,0,0,0, 1,1,0,1,0, 4'b0001};
      tbl[3]  = '{0,0,0,0,0, 1,1,0,1,0, 4'b0011};
      tbl[4]  = '{0,0,0,0,0, 1,1,0,1,0, 4'b0111};
      tbl[5]  = '{0,0,0,0,0, 1,1,0,1,0, 4'b1111};
      tbl[6]  = '{0,0,0,0,0, 1,1,0,1,0, 4'b1111};
      tbl[7]  = '{0,0,1,0,0, 0,0,0,1,0, 4'b1111};
      tbl[8]  = '{0,0,1,0,0, 0,0,0,1,0, 4'b1101};
      tbl[9]  = '{0,0,1,0,0, 0,0,0,1,0, 4'b1001};
      tbl[10] = '{0,0,0,0,0, 1,1,0,1,0, 4'b0001};
      tbl[11] = '{0,0,0,1,0, 0,1,0,1,0, 4'b0011};
      tbl[12] = '{0,0,0,1,0, 0,0,0,1,0, 4'b0110};
      tbl[13] = '{0,0,0,1,1, 0,0,0,1,0, 4'b1100};
      tbl[14] = '{0,0,0,0,0, 0,0,1,1,0, 4'b1000};
      tbl[15] = '{0,0,0,0,0, 1,0,0,1,0, 4'b0000};
      tbl[16] = '{0,0,0,0,0, 1,1,0,1,0, 4'b0001};
      tbl[17] = '{0,1,0,0,0, 0,1,0,1,0, 4'b0011};
      tbl[18] = '{0,0,0,0,0, 0,0,0,1,0, 4'b0110};
      tbl[19] = '{0,0,0,0,0, 0,0,0,1,0, 4'b1100};
      tbl[20] = '{0,0,0,0,0, 0,0,0,1,0, 4'b1000};
      tbl[21] = '{0,0,0,0,0, 0,0,0,1,1, 4'b0000};
      tbl[22] = '{0,0,0,0,0, 0,0,0,0,0, 4'b0000};

      // Reset state
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst.vld", vld_o, 4'b0000);
      chk("rst.outs", {fetch_en_o, dec_en_o, reg_en_o, alu_en_o, wb_en_o, pc_load_o,
                       busy_o, done_o, stall_err_o}, 9'd0);
      chk("rst.perf", {perf_stall_o, perf_bubble_o}, 64'd0);
      arstn = 1'b1;

      // Vector table: fill, stall, branch + redirect, halt + drain
      for (int i = 0; i <= 22; i++) step(tbl[i], 1'b1, $sformatf("tbl%0d", i));
`ifdef PIPE_PERF_CNT_EN
      exp_ps = 3; exp_pb = 4;
`else
      exp_ps = 0; exp_pb = 0;
`endif
      chk("tbl.perf_stall", perf_stall_o, exp_ps);
      chk("tbl.perf_bubble", perf_bubble_o, exp_pb);

      // Halt with a full pipe: done expected on the 4th cycle after the halt cycle
      step(mk(1,0,0,0,0), 1'b0, "h");
      for (int i = 0; i < 5; i++) step(mk(0,0,0,0,0), 1'b0, "h");
      chk("halt.full", vld_o, 4'b1111);
      step(mk(0,1,0,0,0), 1'b0, "h");
      k = 0;
      for (int i = 1; i <= 10; i++) begin
         step(mk(0,0,0,0,0), 1'b0, "h");
         if (done_seen === 1'b1) begin k = i; break; end
      end
      chk("halt.done_cycle", k, 4);
      chk("halt.idle", busy_o, 1'b0);
      chk("halt.perf_stall", perf_stall_o, exp_ps);
      chk("halt.perf_bubble", perf_bubble_o, exp_pb);

      // Stall timeout boundary, and stickiness after release
      step(mk(1,0,0,0,0), 1'b0, "to");
      for (int i = 0; i < 4; i++) step(mk(0,0,0,0,0), 1'b0, "to");
      for (int i = 1; i <= 15; i++) begin
         step(mk(0,0,1,0,0), 1'b0, "to");
         chk($sformatf("timeout.err_after_%0d", i), stall_err_o, (i >= 15) ? 1'b1 : 1'b0);
      end
      for (int i = 0; i < 3; i++) step(mk(0,0,0,0,0), 1'b0, "to");
      chk("timeout.sticky", stall_err_o, 1'b1);

      // Asynchronous reset in the middle of a cycle with a full pipe
      for (int i = 0; i < 4; i++) step(mk(0,0,0,0,0), 1'b0, "ar");
      chk("arst.pre_vld", vld_o, 4'b1111);
      #2 arstn = 1'b0;
      #1;
      chk("arst.vld", vld_o, 4'b0000);
      chk("arst.enables", {fetch_en_o, dec_en_o, reg_en_o, alu_en_o, wb_en_o}, 5'd0);
      chk("arst.busy_err", {busy_o, stall_err_o, pc_load_o, done_o}, 4'd0);
      model_reset();
      @(posedge clk);
      #1 arstn = 1'b1;

      // Randomized run against the model
      rc_hold = 0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 699) == 0) sync_reset_pulse();
         v = mk($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 11) == 0);
         if (rc_hold > 0) begin
            v.rc = 1'b1; v.halt = 1'b0; v.wbd = 1'b0;
            rc_hold--;
         end else if ($urandom_range(0, 149) == 0) begin
            rc_hold = 18;
         end
         step(v, 1'b0, "rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      bad++;
      $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
